// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the 16x4 register-RAM access arbiter.
//   ram_arb_state_t : access sequencer states
//   RAM_ADDR_W / RAM_DATA_W : RAM geometry (16 words of 4 bits)
//   OWN_A / OWN_B : encoding of the owner flag
package ram_arb_pkg;

   localparam int RAM_ADDR_W = 4;
   localparam int RAM_DATA_W = 4;

   localparam logic OWN_A = 1'b0;
   localparam logic OWN_B = 1'b1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      STROBE  = 3'd2,
      HOLD    = 3'd3,
      CAPTURE = 3'd4
   } ram_arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant for the RAM arbiter.
// Purely combinational; the owner register is kept by the caller and the
// result is only consumed while the sequencer is idle.
//   a_req, b_req : pending requests
//   owner        : last grantee (OWN_A / OWN_B)
//   grant_valid  : at least one request pending
//   grant_b      : 1 = B wins, 0 = A wins (meaningful when grant_valid)
module rr_arbiter2
   import ram_arb_pkg::*;
(
   input  logic a_req,
   input  logic b_req,
   input  logic owner,
   output logic grant_valid,
   output logic grant_b
);

   assign grant_valid = a_req | b_req;

   // On a tie the requester that did not own the RAM last time wins.
   assign grant_b = b_req & (~a_req | (owner == OWN_A));

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares the 16x4 edge-clocked register RAM between requester A (CPU
// datapath) and requester B (loader/debug) and sequences every access into
// address-setup / strobe / hold phases so the cells are written cleanly.
//   Clock, nReset            : system clock, async active-low reset
//   a_* / b_*                : request/we/addr/wdata in, ack/rdata out
//   ram_addr, ram_data, ram_w: RAM select, data and write pins
//   ram_q                    : RAM asynchronous read data
//   busy                     : sequencer not idle
//   owner                    : current/last grantee (0 = A, 1 = B)
//
// state   | meaning
// IDLE    | waiting for a request; arbitration and field latch happen here
// SETUP   | address/data settle, ram_w low; reads capture ram_q here
// STROBE  | ram_w high, cell clocks in the data
// HOLD    | ram_w low, address/data still held, write ack
// CAPTURE | read ack with captured rdata
module ram_access_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W
) (
   input  logic              Clock,
   input  logic              nReset,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_w,
   input  logic [DATA_W-1:0] ram_q,
   output logic              busy,
   output logic              owner
);

   ram_arb_state_t state;
   ram_arb_state_t state_nxt;
   logic           lat_we;
   logic           grant_valid;
   logic           grant_b;
   logic           grant_take;
   logic           acc_done;

   rr_arbiter2 u_rr_arbiter2 (
      .a_req       (a_req),
      .b_req       (b_req),
      .owner       (owner),
      .grant_valid (grant_valid),
      .grant_b     (grant_b)
   );

   assign grant_take = (state == IDLE) && grant_valid;

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ram_w, busy and the acks decode straight from the state register so an
   // asynchronous reset forces them low without waiting for a clock edge.
   always_comb begin
      state_nxt = state;
      ram_w     = 1'b0;
      busy      = 1'b1;
      acc_done  = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (grant_valid) begin
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            state_nxt = lat_we ? STROBE : CAPTURE;
         end
         STROBE: begin
            ram_w     = 1'b1;
            state_nxt = HOLD;
         end
         HOLD: begin
            acc_done  = 1'b1;
            state_nxt = IDLE;
         end
         CAPTURE: begin
            acc_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      a_ack = acc_done && (owner == OWN_A);
      b_ack = acc_done && (owner == OWN_B);
   end

   // ram_addr/ram_data double as the latched request fields, so they can
   // only move on the IDLE->SETUP edge and stay put across the strobe.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         owner    <= OWN_B;
         lat_we   <= 1'b0;
         ram_addr <= '0;
         ram_data <= '0;
      end else if (grant_take) begin
         owner    <= grant_b ? OWN_B : OWN_A;
         lat_we   <= grant_b ? b_we : a_we;
         ram_addr <= grant_b ? b_addr : a_addr;
         ram_data <= grant_b ? b_wdata : a_wdata;
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         a_rdata <= '0;
         b_rdata <= '0;
      end else if ((state == SETUP) && !lat_we) begin
         if (owner == OWN_A) begin
            a_rdata <= ram_q;
         end else begin
            b_rdata <= ram_q;
         end
      end
   end

endmodule

// File: doc/ram_access_arbiter.md
# ram_access_arbiter

Two-port access controller for the 16×4 register RAM (16 edge-triggered 4-bit cells, demultiplexed write strobe, asynchronous read mux). It shares the RAM between requester A (CPU datapath) and requester B (program loader/debug port) using round-robin arbitration. It sequences each access into address-setup / strobe / hold phases so the edge-clocked cells are written cleanly. It sits between the requesters and the RAM's data, address and `w` pins.

## Interface
Parameters:
- `ADDR_W`, 4, RAM address width (16 words)
- `DATA_W`, 4, RAM word width

Ports:
- `Clock`  in  1  single system clock, rising-edge
- `nReset`  in  1  asynchronous, active-low reset
- `a_req`  in  1  requester A access request; held with fields stable until `a_ack`
- `a_we`  in  1  1 = write, 0 = read
- `a_addr`  in  ADDR_W  word address
- `a_wdata`  in  DATA_W  write data
- `a_ack`  out  1  one-cycle completion pulse
- `a_rdata`  out  DATA_W  read data, valid while `a_ack`=1
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_ack`, `b_rdata`: identical set for requester B
- `ram_addr`  out  ADDR_W  to RAM select input
- `ram_data`  out  DATA_W  to RAM data input
- `ram_w`  out  1  to RAM write input (demuxed to the cell clock)
- `ram_q`  in  DATA_W  from RAM read mux
- `busy`  out  1  1 whenever state ≠ IDLE
- `owner`  out  1  current/last grantee: 0 = A, 1 = B

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, CAPTURE.
- IDLE:
  - On any req, grant and latch the winner's `we`/`addr`/`wdata` into internal registers.
  - Go to SETUP.
- Arbitration:
  - With a single requester, that requester wins.
  - If both requesters are active, the one that is not `owner` wins (round-robin).
  - `owner` resets to 1, so A wins the first tie.
- SETUP:
  - `ram_addr`/`ram_data` driven from the latched values, `ram_w`=0.
  - Write → STROBE.
  - Read → capture `ram_q` into the grantee's rdata register, then → CAPTURE.
- STROBE: `ram_w`=1, address/data unchanged → HOLD.
- HOLD: `ram_w`=0, address/data unchanged, grantee ack=1 → IDLE.
- CAPTURE: grantee ack=1, rdata valid → IDLE.
- `ram_addr`/`ram_data` change only on the IDLE→SETUP edge. They stay stable across every `ram_w` transition.
- Rdata registers hold their last value until the next read by that requester.
- The non-granted ack is always 0.
- A req still high in the cycle after its ack is treated as a new transaction.
- Requests that change fields before ack are undefined; they are not checked.

## Timing
- Reset values: state IDLE; `ram_w`, `ram_addr`, `ram_data`, `a_ack`, `b_ack`, `a_rdata`, `b_rdata`, `busy` all 0; `owner`=1.
- Cycle 0 = first rising edge with req sampled high in IDLE.
- Write:
  - SETUP in cycle 1, STROBE in cycle 2 (`ram_w`=1), ack in cycle 3.
  - The RAM cell updates at the `ram_w` rise, in cycle 2.
- Read: SETUP in cycle 1, ack with rdata in cycle 2.
- At least one IDLE cycle occurs between transactions. Peak throughput is one write per 4 cycles and one read per 3 cycles.
- Simultaneous requests with `owner`=1: A served first; B is granted in the IDLE cycle after A's ack.
- Starvation bound: a waiting requester is granted within one transaction of the other.
- `nReset` asserted mid-operation:
  - All outputs go to reset values immediately (asynchronous), including `ram_w`→0.
  - The RAM is not written unless `ram_w` had already risen.
  - No ack is produced for the aborted access.
- `nReset` deassertion: the first FSM transition happens no earlier than the next rising edge.

## Structure
- Package `ram_arb_pkg`:
  - state enum `ram_arb_state_t` (IDLE, SETUP, STROBE, HOLD, CAPTURE)
  - constants `RAM_ADDR_W`=4, `RAM_DATA_W`=4
  - owner encodings `OWN_A`=0, `OWN_B`=1
- Sub-module `rr_arbiter2`:
  - Combinational grant from `a_req`, `b_req`, `owner`.
  - Used only in IDLE; the `owner` register lives in the top.
- Top: FSM, latched request registers, two rdata registers, ack generation.

## Test plan
- Reset: `nReset` low with random inputs → all outputs 0, `owner`=1; after release, no `ram_w` pulse without req.
- A writes 0xA to addr 3:
  - Required waveform: cycle 1 `ram_addr`=3, `ram_data`=0xA, `ram_w`=0; cycle 2 `ram_w`=1; cycle 3 `a_ack`=1, `ram_w`=0.
  - Follow-up: A reads addr 3 → `a_rdata`=0xA with `a_ack` 2 cycles after req.
- Contention:
  - A writes 0x5 to addr 7 and B reads addr 7, both raised in the same cycle.
  - A is served first; B is granted next with `b_rdata`=0x5.
  - `owner` sequence 0 then 1.
- Round-robin: A and B both hold req continuously → grants alternate A, B, A, B; no requester misses more than one turn.
- Reset mid-write: assert `nReset` during STROBE → `ram_w` drops immediately, no `a_ack`; after release, A's repeated write of 0xC to addr 0 completes normally.
- Back-to-back reads by B of addrs 0..15 after the loader has filled them with values 0xF−i → each `b_rdata` = 0xF−i, one read every 3 cycles.
